// File: rtl/sha3_msg_tx_pkg.sv
// Shared constants and types for the SHA3-256 message formatter/transmitter.
// Holds the rate and chunk geometry, the pad byte values and the FSM state type.
package sha3_pkg;

    localparam int unsigned RATE_BYTES      = 136;
    localparam int unsigned CHUNK_BITS      = 200;
    localparam int unsigned NCHUNKS         = 8;
    localparam int unsigned BYTES_PER_CHUNK = 25;
    localparam int unsigned STATE_BITS      = CHUNK_BITS * NCHUNKS;
    localparam int unsigned CNT_W           = 8;   // byte count, saturates at RATE_BYTES
    localparam int unsigned IX_W            = 3;   // chunk index

    localparam logic [7:0] PAD_SHA3   = 8'h06;
    localparam logic [7:0] PAD_KECCAK = 8'h01;
    localparam logic [7:0] PAD_END    = 8'h80;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SEND    = 2'd1,
        WAIT    = 2'd2
    } tx_state_t;

endpackage

// File: rtl/sha3_msg_tx_if.sv
// Message-in and perm-side bus of sha3_msg_tx.
//   msg side : pushmsg, msgbyte, msgkeep, msglast (to block); stopmsg, ovf (from block)
//   perm side: pushin, dix, din (to perm); pushout, doutix (from perm)
// slave = the transmitter, master = the environment driving it.
interface sha3_msg_tx_if;
    import sha3_pkg::*;

    logic                  pushmsg;
    logic [7:0]            msgbyte;
    logic                  msgkeep;
    logic                  msglast;
    logic                  stopmsg;
    logic                  ovf;
    logic                  pushin;
    logic [IX_W-1:0]       dix;
    logic [CHUNK_BITS-1:0] din;
    logic                  pushout;
    logic [IX_W-1:0]       doutix;

    modport slave (
        input  pushmsg, msgbyte, msgkeep, msglast, pushout, doutix,
        output stopmsg, ovf, pushin, dix, din
    );

    modport master (
        output pushmsg, msgbyte, msgkeep, msglast, pushout, doutix,
        input  stopmsg, ovf, pushin, dix, din
    );

endinterface

// File: rtl/sha3_pad_buf.sv
// 1088-bit rate buffer: byte-indexed write and pad XOR, chunk-indexed read.
// Ports: clk, reset (sync, active-high); clr zeroes the buffer; wr_en/wr_idx/wr_byte
// store a message byte; pad_en/pad_idx/pad_byte XOR the domain pad into pad_idx and
// the final 0x80 into the last rate byte; rd_ix selects a 200-bit chunk on rd_data_c.
// rd_data_c reflects the buffer contents after this cycle's update, so a byte and its
// padding written in one cycle are visible in the same cycle's read.
module sha3_pad_buf
    import sha3_pkg::*;
(
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clr,
    input  logic                  wr_en,
    input  logic [CNT_W-1:0]      wr_idx,
    input  logic [7:0]            wr_byte,
    input  logic                  pad_en,
    input  logic [CNT_W-1:0]      pad_idx,
    input  logic [7:0]            pad_byte,
    input  logic [IX_W-1:0]       rd_ix,
    output logic [CHUNK_BITS-1:0] rd_data_c
);

    logic [RATE_BYTES-1:0][7:0] buf_q;
    logic [RATE_BYTES-1:0][7:0] buf_d;
    logic [STATE_BITS-1:0]      state_c;

    // Byte write first, then padding, so a last byte at index 135 is padded on top.
    always_comb begin
        buf_d = buf_q;
        if (wr_en) begin
            buf_d[wr_idx] = wr_byte;
        end
        if (pad_en) begin
            buf_d[pad_idx]        = buf_d[pad_idx] ^ pad_byte;
            buf_d[RATE_BYTES-1]   = buf_d[RATE_BYTES-1] ^ PAD_END;
        end
        if (clr) begin
            buf_d = '0;
        end
    end

    // Capacity bytes 136..199 are always zero.
    always_comb begin
        state_c   = STATE_BITS'(buf_d);
        rd_data_c = state_c[11'(rd_ix) * 11'(CHUNK_BITS) +: CHUNK_BITS];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            buf_q <= '0;
        end else begin
            buf_q <= buf_d;
        end
    end

endmodule

// File: rtl/sha3_msg_tx.sv
// SHA3-256 message formatter/transmitter: collects up to 135 message bytes, applies
// multi-rate padding and sends the 1600-bit state to perm as eight 200-bit chunks,
// then holds off the next message until perm reports chunk 7 out.
// Ports: clk, reset (sync, active-high), bus (sha3_msg_tx_if.slave).
// Parameter WAIT_PERM: 1 = wait for perm completion, 0 = back to COLLECT after chunk 7.
// Build option SHA3_TX_KECCAK_PAD_EN: defined selects pad byte 0x01, else 0x06.
module sha3_msg_tx
    import sha3_pkg::*;
#(
    parameter bit WAIT_PERM = 1'b1
) (
    input  logic          clk,
    input  logic          reset,
    sha3_msg_tx_if.slave  bus
);

`ifdef SHA3_TX_KECCAK_PAD_EN
    localparam logic [7:0] PAD_BYTE = PAD_KECCAK;
`else
    localparam logic [7:0] PAD_BYTE = PAD_SHA3;
`endif

    localparam logic [CNT_W-1:0] LAST_IX    = CNT_W'(RATE_BYTES - 1);
    localparam logic [CNT_W-1:0] N_SAT      = CNT_W'(RATE_BYTES);
    localparam logic [IX_W-1:0]  LAST_CHUNK = IX_W'(NCHUNKS - 1);

    tx_state_t             state_q, state_d;
    logic [CNT_W-1:0]      n_q, n_d;
    logic [IX_W-1:0]       chunk_q, chunk_d;
    logic                  pushin_q, pushin_d;
    logic [IX_W-1:0]       dix_q, dix_d;
    logic [CHUNK_BITS-1:0] din_q, din_d;
    logic                  stopmsg_q, stopmsg_d;
    logic                  ovf_q, ovf_d;

    logic                  accept_c;
    logic [CNT_W-1:0]      n_next_c;
    logic                  buf_wr_c;
    logic                  buf_pad_c;
    logic [CNT_W-1:0]      pad_idx_c;
    logic                  send_done_c;
    logic [IX_W-1:0]       rd_ix_c;
    logic [CHUNK_BITS-1:0] rd_data_c;

    // Buffer control decode; n saturates at 136 so byte 135 is the last one written.
    always_comb begin
        accept_c    = (state_q == COLLECT) && bus.pushmsg;
        n_next_c    = n_q;
        if (accept_c && bus.msgkeep && (n_q != N_SAT)) begin
            n_next_c = n_q + CNT_W'(1);
        end
        buf_wr_c    = accept_c && bus.msgkeep && (n_q <= LAST_IX);
        buf_pad_c   = accept_c && bus.msglast;
        pad_idx_c   = (n_next_c > LAST_IX) ? LAST_IX : n_next_c;
        send_done_c = (state_q == SEND) && (chunk_q == LAST_CHUNK);
        rd_ix_c     = (state_q == SEND) ? chunk_q : '0;
    end

    sha3_pad_buf u_buf (
        .clk       (clk),
        .reset     (reset),
        .clr       (send_done_c),
        .wr_en     (buf_wr_c),
        .wr_idx    (n_q),
        .wr_byte   (bus.msgbyte),
        .pad_en    (buf_pad_c),
        .pad_idx   (pad_idx_c),
        .pad_byte  (PAD_BYTE),
        .rd_ix     (rd_ix_c),
        .rd_data_c (rd_data_c)
    );

    // Next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        n_d       = n_q;
        chunk_d   = chunk_q;
        ovf_d     = ovf_q;
        pushin_d  = 1'b0;
        dix_d     = '0;
        din_d     = '0;

        case (state_q)
            COLLECT: begin
                if (accept_c) begin
                    n_d = n_next_c;
                    // n==0 marks the first beat of a message: drop the old overflow flag.
                    if (n_q == '0) begin
                        ovf_d = 1'b0;
                    end
                    if (bus.msgkeep && (n_q >= LAST_IX)) begin
                        ovf_d = 1'b1;
                    end
                    if (bus.msglast) begin
                        state_d  = SEND;
                        chunk_d  = IX_W'(1);
                        pushin_d = 1'b1;
                        din_d    = rd_data_c;
                    end
                end
            end
            SEND: begin
                pushin_d = 1'b1;
                dix_d    = chunk_q;
                din_d    = rd_data_c;
                chunk_d  = chunk_q + IX_W'(1);
                // Chunk 7 is pure capacity, so reading the cleared buffer is harmless.
                if (send_done_c) begin
                    n_d     = '0;
                    chunk_d = '0;
                    if (WAIT_PERM) begin
                        state_d = WAIT;
                    end else begin
                        state_d = COLLECT;
                    end
                end
            end
            WAIT: begin
                if (bus.pushout && (bus.doutix == LAST_CHUNK)) begin
                    state_d = COLLECT;
                end
            end
            default: begin
                state_d = COLLECT;
            end
        endcase

        stopmsg_d = (state_d != COLLECT);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= COLLECT;
            n_q       <= '0;
            chunk_q   <= '0;
            pushin_q  <= 1'b0;
            dix_q     <= '0;
            din_q     <= '0;
            stopmsg_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            n_q       <= n_d;
            chunk_q   <= chunk_d;
            pushin_q  <= pushin_d;
            dix_q     <= dix_d;
            din_q     <= din_d;
            stopmsg_q <= stopmsg_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.pushin  = pushin_q;
    assign bus.dix     = dix_q;
    assign bus.din     = din_q;
    assign bus.stopmsg = stopmsg_q;
    assign bus.ovf     = ovf_q;

endmodule

// File: tb/tb_sha3_msg_tx.sv
// Directed bench for sha3_msg_tx with a chunk scoreboard filled from a byte-level
// padding model when each message is driven.
module tb_sha3_msg_tx;

`ifdef SHA3_TX_KECCAK_PAD_EN
    localparam logic [7:0] EXP_PAD = 8'h01;
`else
    localparam logic [7:0] EXP_PAD = 8'h06;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sha3_msg_tx_if bus ();

    sha3_msg_tx #(.WAIT_PERM(1'b1)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;

    logic [7:0]   msg_q [$];
    logic [199:0] exp_q [$];
    logic         exp_ovf;
    logic [199:0] got [8];
    logic [199:0] tmp;

    task automatic check(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Model: state bytes = message bytes (first 136 only), pad at min(len,135), 0x80 at 135.
    task automatic push_expected();
        logic [7:0]   st [200];
        logic [199:0] ch;
        int len, lim, p;
        for (int i = 0; i < 200; i++) st[i] = 8'h00;
        len = msg_q.size();
        lim = (len < 136) ? len : 136;
        for (int i = 0; i < lim; i++) st[i] = msg_q[i];
        p = (len < 135) ? len : 135;
        st[p]   = st[p] ^ EXP_PAD;
        st[135] = st[135] ^ 8'h80;
        for (int c = 0; c < 8; c++) begin
            ch = '0;
            for (int b = 0; b < 25; b++) ch[b*8 +: 8] = st[c*25 + b];
            exp_q.push_back(ch);
        end
        exp_ovf = (len > 135);
    endtask

    // last_keep=1: final data beat carries msglast; 0: extra empty terminating beat.
    task automatic drive_msg(input bit last_keep);
        for (int i = 0; i < msg_q.size(); i++) begin
            bus.pushmsg = 1'b1;
            bus.msgbyte = msg_q[i];
            bus.msgkeep = 1'b1;
            bus.msglast = last_keep && (i == msg_q.size() - 1);
            @(posedge clk); #1;
        end
        if (!last_keep) begin
            bus.pushmsg = 1'b1;
            bus.msgbyte = 8'h00;
            bus.msgkeep = 1'b0;
            bus.msglast = 1'b1;
            @(posedge clk); #1;
        end
        bus.pushmsg = 1'b0;
        bus.msgkeep = 1'b0;
        bus.msglast = 1'b0;
    endtask

    task automatic collect_burst(input string tag);
        int w = 0;
        logic [199:0] e;
        while (bus.pushin !== 1'b1 && w < 4) begin
            @(posedge clk); #1;
            w++;
        end
        check({tag, " latency"}, 200'(w), 200'(0));
        for (int k = 0; k < 8; k++) begin
            e = (exp_q.size() > 0) ? exp_q.pop_front() : '0;
            got[k] = bus.din;
            check($sformatf("%s pushin%0d", tag, k), 200'(bus.pushin), 200'(1));
            check($sformatf("%s dix%0d", tag, k), 200'(bus.dix), 200'(k));
            check($sformatf("%s din%0d", tag, k), bus.din, e);
            check($sformatf("%s stopmsg%0d", tag, k), 200'(bus.stopmsg), 200'(1));
            if (k == 0) check({tag, " ovf"}, 200'(bus.ovf), 200'(exp_ovf));
            @(posedge clk); #1;
        end
        check({tag, " pushin_end"}, 200'(bus.pushin), 200'(0));
        check({tag, " dix_end"}, 200'(bus.dix), 200'(0));
        check({tag, " din_end"}, bus.din, 200'(0));
        check({tag, " stopmsg_wait"}, 200'(bus.stopmsg), 200'(1));
    endtask

    task automatic release_perm(input string tag);
        bus.pushout = 1'b1;
        bus.doutix  = 3'd3;
        @(posedge clk); #1;
        check({tag, " hold_on_ix3"}, 200'(bus.stopmsg), 200'(1));
        bus.doutix  = 3'd7;
        @(posedge clk); #1;
        bus.pushout = 1'b0;
        bus.doutix  = 3'd0;
        check({tag, " released"}, 200'(bus.stopmsg), 200'(0));
    endtask

    task automatic load_abc();
        msg_q.delete();
        msg_q.push_back(8'h61);
        msg_q.push_back(8'h62);
        msg_q.push_back(8'h63);
        msg_q.push_back(8'h0a);
    endtask

    initial begin
        int w;
        reset = 1'b1;
        bus.pushmsg = 1'b0;
        bus.msgbyte = 8'h00;
        bus.msgkeep = 1'b0;
        bus.msglast = 1'b0;
        bus.pushout = 1'b0;
        bus.doutix  = 3'd0;
        repeat (3) @(posedge clk);
        #1;
        check("rst pushin", 200'(bus.pushin), 200'(0));
        check("rst dix", 200'(bus.dix), 200'(0));
        check("rst din", bus.din, 200'(0));
        check("rst stopmsg", 200'(bus.stopmsg), 200'(0));
        check("rst ovf", 200'(bus.ovf), 200'(0));
        reset = 1'b0;
        @(posedge clk); #1;

        // "abc\n"
        load_abc();
        push_expected();
        drive_msg(1'b1);
        collect_burst("abc");
        tmp = 200'h60a636261;
        tmp[39:32] = EXP_PAD ^ 8'h0a ^ 8'h0a;
        check("abc chunk0 lit", got[0], tmp);
        tmp = 200'(8'h80) << 80;
        check("abc chunk5 lit", got[5], tmp);
        release_perm("abc");

        // Empty message
        msg_q.delete();
        push_expected();
        drive_msg(1'b0);
        collect_burst("empty");
        check("empty chunk0 lit", got[0], 200'(EXP_PAD));
        release_perm("empty");

        // 135 zero bytes: pad and end bit land in the same byte
        msg_q.delete();
        for (int i = 0; i < 135; i++) msg_q.push_back(8'h00);
        push_expected();
        drive_msg(1'b1);
        collect_burst("z135");
        tmp = 200'(EXP_PAD ^ 8'h80) << 80;
        check("z135 chunk5 lit", got[5], tmp);
        release_perm("z135");

        // 137 bytes of 0xFF: overflow, nothing written past byte 135
        msg_q.delete();
        for (int i = 0; i < 137; i++) msg_q.push_back(8'hff);
        push_expected();
        drive_msg(1'b1);
        collect_burst("f137");
        tmp = 200'(got[5][87:80]);
        check("f137 byte135", tmp, 200'(8'hff ^ EXP_PAD ^ 8'h80));
        check("f137 above135", got[5] >> 88, 200'(0));

        // Beats pushed during WAIT are ignored and ovf stays sticky
        for (int i = 0; i < 5; i++) begin
            bus.pushmsg = 1'b1;
            bus.msgbyte = 8'h55;
            bus.msgkeep = 1'b1;
            bus.msglast = (i == 4);
            @(posedge clk); #1;
            check($sformatf("hold stopmsg%0d", i), 200'(bus.stopmsg), 200'(1));
            check($sformatf("hold pushin%0d", i), 200'(bus.pushin), 200'(0));
            check($sformatf("hold ovf%0d", i), 200'(bus.ovf), 200'(1));
        end
        bus.pushmsg = 1'b0;
        bus.msgkeep = 1'b0;
        bus.msglast = 1'b0;
        release_perm("f137");

        // Re-pushed message after release; ovf cleared by its first beat
        load_abc();
        push_expected();
        drive_msg(1'b1);
        collect_burst("abc2");
        check("abc2 chunk0 lit", got[0], 200'h60a636261 | (200'(EXP_PAD ^ 8'h06) << 32));
        release_perm("abc2");

        // Reset during chunk 3 abandons the burst
        load_abc();
        push_expected();
        drive_msg(1'b1);
        w = 0;
        while (!(bus.pushin === 1'b1 && bus.dix === 3'd3) && w < 12) begin
            @(posedge clk); #1;
            w++;
        end
        check("mid chunk3 reached", 200'(w), 200'(3));
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        check("mid rst pushin", 200'(bus.pushin), 200'(0));
        check("mid rst stopmsg", 200'(bus.stopmsg), 200'(0));
        check("mid rst dix", 200'(bus.dix), 200'(0));
        exp_q.delete();

        load_abc();
        push_expected();
        drive_msg(1'b1);
        collect_burst("abc3");
        check("abc3 chunk0 lit", got[0], 200'h60a636261 | (200'(EXP_PAD ^ 8'h06) << 32));
        tmp = 200'(8'h80) << 80;
        check("abc3 chunk5 lit", got[5], tmp);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
